dvp_capture_ctrl: RTL and testbench
===================================

# dvp_capture_ctrl

Frame-capture controller placed directly after the DVP receiver in the `pclk` domain. It gates the receiver's AXI-Stream output so that only whole frames reach downstream logic. It supports single-shot and continuous capture, marks start of frame on `TUSER`, and checks each frame's geometry against the configured resolution.

## Interface
Parameters:
- `FRAME_BYTES_PER_LINE`, default 1280: expected `href` cycles per line (640 px × 2 B).
- `FRAME_LINES`, default 480: expected lines per frame.
- `HREF_ACTIVE_HIGH`, default 1: polarity of `href_in`. When 0, the input is inverted internally.
- `CNT_W`, default 20: width of the frame byte counter. Must hold `FRAME_BYTES_PER_LINE*FRAME_LINES`.

Ports:
- `pclk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `s_tdata`  in  8  receiver stream data.
- `s_tvalid`  in  1  receiver stream valid. There is no backpressure.
- `s_tlast`  in  1  receiver end-of-frame.
- `href_in`  in  1  raw HREF from the sensor pins.
- `start`  in  1  one-cycle pulse that arms a capture.
- `continuous`  in  1  sampled at `start`: 1 selects continuous mode, 0 selects single-shot.
- `stop`  in  1  one-cycle pulse requesting a graceful stop.
- `m_tdata`  out  8  forwarded data.
- `m_tvalid`  out  1  forwarded valid. The downstream sink must accept every beat.
- `m_tlast`  out  1  last beat of frame.
- `m_tuser`  out  1  first beat of frame.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each captured frame.
- `frame_err`  out  1  geometry result for the last frame; valid from `frame_done` until the next `frame_done`.
- `frame_cnt`  out  16  number of frames completed since reset; wraps at 0xFFFF→0.
- `last_bytes`  out  CNT_W  beat count of the last frame.
- `last_lines`  out  12  line count of the last frame.

## Operation
- States are IDLE, ARMED, CAPTURE.
- **IDLE**:
  - `start` → ARMED, and latch `continuous` into `cont_r`.
  - `stop` is ignored.
- **ARMED**: discards beats until the first `s_tvalid & s_tlast`. That beat is not forwarded. The state then moves to CAPTURE, the counters clear and `sof_pending` is set.
  - `stop` in ARMED → IDLE on the next cycle.
- **CAPTURE**: forwards every `s_tvalid` beat.
  - The first forwarded beat carries `m_tuser=1`, and `sof_pending` then clears.
  - On the `s_tlast` beat: `m_tlast=1`, `frame_done` pulses, status registers load, and `frame_cnt` increments.
  - Then, if `cont_r` is set and no stop is pending, stay in CAPTURE with counters cleared and `sof_pending` set. Otherwise go to IDLE.
- `stop` in CAPTURE sets `stop_pending`. The current frame completes and the block then goes to IDLE.
- `stop` on the same cycle as the `s_tlast` beat: that frame completes and the block goes to IDLE.
- `start` while not IDLE is ignored. `start` and `stop` together in IDLE → ARMED.
- Byte counter counts forwarded beats, including the tlast beat, and saturates at all-ones.
- Line counting runs only in CAPTURE:
  - The line counter increments on each falling edge of the polarity-corrected `href`, detected against a registered copy.
  - A per-line length counter counts `href`-high cycles. At each falling edge it is compared to `FRAME_BYTES_PER_LINE`; a mismatch sets `line_bad`, which is cleared at frame start.
- `frame_err` = (bytes ≠ `FRAME_BYTES_PER_LINE*FRAME_LINES`) | (lines ≠ `FRAME_LINES`) | `line_bad`.
- If an `href` falling edge and the tlast beat occur in the same cycle, the line is counted before the comparison.
- `rst` mid-frame → IDLE immediately. The truncated frame is never terminated with `m_tlast`.

## Timing
- The forward path is registered with 1-cycle latency: a beat at input cycle n appears on `m_*` at cycle n+1.
- `m_tvalid` is 0 in any cycle without a forwarded beat. `m_tdata` holds its value when not valid.
- `frame_done`, `frame_err`, `last_bytes`, `last_lines` and `frame_cnt` update in the same cycle that `m_tlast` is asserted.
- `busy` drops in the cycle after the final `m_tlast`.
- ARMED→IDLE on `stop` takes 1 cycle.
- Reset values: `m_tvalid=0`, `m_tlast=0`, `m_tuser=0`, `m_tdata=0`, `busy=0`, `frame_done=0`, `frame_err=0`, `frame_cnt=0`, `last_bytes=0`, `last_lines=0`. State resets to IDLE.

## Configuration
- `DVP_CAPTURE_SIZE_CHECK_EN`:
  - Defined: line counters, line-length checking and `frame_err` are built as described above.
  - Undefined: only the byte counter remains. `frame_err` is tied to 0 and `last_lines` is tied to 0. Forwarding, FSM and `frame_cnt` behave identically in both builds.

## Test plan
- Parameters 4 B/line × 3 lines; `start` with `continuous=0` in the middle of a frame → partial frame dropped. The next full frame is forwarded as 12 beats, `m_tuser` on beat 1, `m_tlast` on beat 12, `frame_done=1`, `frame_err=0`, `last_bytes=12`, `last_lines=3`, `frame_cnt=1`, then IDLE.
- Continuous mode for 3 frames, with `stop` pulsed during frame 3 → 3 frames forwarded, `frame_cnt=3`, `busy=0` one cycle after the third `m_tlast`.
- Frame with one 5-byte line (13 beats) → `frame_err=1`, `last_bytes=13`. The next correct frame gives `frame_err=0`.
- `stop` while ARMED → IDLE next cycle. No `m_tvalid` is ever asserted.
- `rst` asserted in the middle of CAPTURE → all outputs return to reset values the next cycle. A new `start` captures normally.
- With `DVP_CAPTURE_SIZE_CHECK_EN` undefined, the same bad-line frame → `frame_err=0`, `last_lines=0`, `last_bytes=13`.

Source files
------------

// File: rtl/dvp_capture_ctrl.sv
// Frame-capture gate after the DVP receiver: forwards whole frames only, tags SOF/EOF, checks geometry.
// Optional build macro DVP_CAPTURE_SIZE_CHECK_EN adds line counting and frame_err.
module dvp_capture_ctrl #(
  parameter int unsigned FRAME_BYTES_PER_LINE = 1280,
  parameter int unsigned FRAME_LINES          = 480,
  parameter bit          HREF_ACTIVE_HIGH     = 1'b1,
  parameter int unsigned CNT_W                = 20
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  input  logic             href_in,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] last_bytes,
  output logic [11:0]      last_lines
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_e;

  state_e           state_q, state_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic             sof_q, sof_d;
  logic [CNT_W-1:0] byte_q, byte_d, bytes_tot;
  logic             fwd, eof, frame_start;
  logic             err_now;
  logic [11:0]      lines_tot;

  logic [7:0]       m_tdata_q;
  logic             m_tvalid_q, m_tlast_q, m_tuser_q, frame_done_q, frame_err_q;
  logic [15:0]      frame_cnt_q;
  logic [CNT_W-1:0] last_bytes_q;
  logic [11:0]      last_lines_q;

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    sof_d       = sof_q;
    frame_start = 1'b0;
    fwd         = 1'b0;
    eof         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ARMED;
          cont_d      = continuous;
          stop_pend_d = 1'b0;
        end
      end
      S_ARMED: begin
        // the closing beat of the partial frame is swallowed; capture starts after it
        if (stop) state_d = S_IDLE;
        else if (s_tvalid && s_tlast) begin
          state_d     = S_CAPTURE;
          frame_start = 1'b1;
        end
      end
      S_CAPTURE: begin
        fwd = s_tvalid;
        if (stop) stop_pend_d = 1'b1;
        if (s_tvalid) sof_d = 1'b0;
        if (s_tvalid && s_tlast) begin
          eof = 1'b1;
          if (cont_q && !stop_pend_q && !stop) frame_start = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_start) sof_d = 1'b1;
  end

  // saturating beat count; bytes_tot already includes the beat in flight
  assign bytes_tot = (&byte_q) ? byte_q : byte_q + 1'b1;

  always_comb begin
    byte_d = byte_q;
    if (frame_start) byte_d = '0;
    else if (fwd)    byte_d = bytes_tot;
  end

`ifdef DVP_CAPTURE_SIZE_CHECK_EN
  localparam int unsigned EXP_BYTES = FRAME_BYTES_PER_LINE * FRAME_LINES;

  logic             href_c, href_q, href_fall;
  logic [11:0]      line_q, line_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             line_bad_q, line_bad_d, line_bad_tot;

  assign href_c       = HREF_ACTIVE_HIGH ? href_in : ~href_in;
  assign href_fall    = href_q & ~href_c;
  // a line ending on the tlast beat is counted and checked before the verdict
  assign lines_tot    = line_q + {11'd0, href_fall};
  assign line_bad_tot = line_bad_q | (href_fall && (len_q != CNT_W'(FRAME_BYTES_PER_LINE)));
  assign err_now      = (bytes_tot != CNT_W'(EXP_BYTES)) | (lines_tot != 12'(FRAME_LINES)) | line_bad_tot;

  always_comb begin
    line_d     = line_q;
    len_d      = len_q;
    line_bad_d = line_bad_q;
    if (frame_start) begin
      line_d     = '0;
      len_d      = '0;
      line_bad_d = 1'b0;
    end else if (state_q == S_CAPTURE) begin
      if (href_fall) begin
        line_d     = lines_tot;
        len_d      = '0;
        line_bad_d = line_bad_tot;
      end else if (href_c) begin
        len_d = len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      href_q     <= 1'b0;
      line_q     <= '0;
      len_q      <= '0;
      line_bad_q <= 1'b0;
    end else begin
      href_q     <= href_c;
      line_q     <= line_d;
      len_q      <= len_d;
      line_bad_q <= line_bad_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = href_in ^ HREF_ACTIVE_HIGH ^ (FRAME_LINES != FRAME_BYTES_PER_LINE);
  assign err_now    = 1'b0;
  assign lines_tot  = '0;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      sof_q        <= 1'b0;
      byte_q       <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      last_bytes_q <= '0;
      last_lines_q <= '0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      sof_q        <= sof_d;
      byte_q       <= byte_d;
      m_tvalid_q   <= fwd;
      m_tuser_q    <= fwd & sof_q;
      m_tlast_q    <= eof;
      frame_done_q <= eof;
      if (fwd) m_tdata_q <= s_tdata;
      if (eof) begin
        frame_cnt_q  <= frame_cnt_q + 16'd1;
        last_bytes_q <= bytes_tot;
        last_lines_q <= lines_tot;
        frame_err_q  <= err_now;
      end
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign m_tuser    = m_tuser_q;
  // held through the final m_tlast so busy falls one cycle after it
  assign busy       = (state_q != S_IDLE) | m_tlast_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign last_bytes = last_bytes_q;
  assign last_lines = last_lines_q;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Bench for dvp_capture_ctrl: 4 B/line x 3 lines, frame-level reference model plus literal checkpoints.
module tb_dvp_capture_ctrl;
  localparam int BPL = 4, NL = 3, CW = 8;
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic          pclk = 1'b0, rst = 1'b1;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 0, s_tlast = 0, href_in = 0, start = 0, continuous = 0, stop = 0;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tlast, m_tuser, busy, frame_done, frame_err;
  logic [15:0]   frame_cnt;
  logic [CW-1:0] last_bytes;
  logic [11:0]   last_lines;

  int checks = 0, errors = 0;
  int fwd_beats = 0, sof_beats = 0;
  bit chk_en = 1'b0;
  logic [7:0] dctr = 8'h10;

  always #5 pclk = ~pclk;

  dvp_capture_ctrl #(.FRAME_BYTES_PER_LINE(BPL), .FRAME_LINES(NL), .HREF_ACTIVE_HIGH(1'b1), .CNT_W(CW)) dut (
    .pclk(pclk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .href_in(href_in), .start(start), .continuous(continuous), .stop(stop),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .last_bytes(last_bytes), .last_lines(last_lines));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle / 1 armed / 2 capture; geometry from recorded href run lengths
  int mode = 0, beats = 0, run_len = 0;
  bit cont_m, stop_m, sof_m, href_prev;
  int runs[$];
  bit e_valid, e_user, e_last, e_done, e_err, e_busy;
  logic [7:0] e_data;
  int e_cnt, e_bytes, e_lines;

  always @(posedge pclk) begin
    if (rst) begin
      mode = 0; beats = 0; run_len = 0; runs.delete(); href_prev = 0;
      cont_m = 0; stop_m = 0; sof_m = 0;
      e_valid = 0; e_user = 0; e_last = 0; e_done = 0; e_err = 0; e_busy = 0;
      e_data = 0; e_cnt = 0; e_bytes = 0; e_lines = 0;
    end else begin
      e_valid = 0; e_user = 0; e_last = 0; e_done = 0;
      if (mode == 2) begin
        if (href_in) run_len++;
        else if (href_prev) begin runs.push_back(run_len); run_len = 0; end
        if (stop) stop_m = 1;
        if (s_tvalid) begin
          e_valid = 1; e_data = s_tdata; e_user = sof_m; sof_m = 0; beats++;
          if (s_tlast) begin
            bit bad = 0;
            foreach (runs[i]) if (runs[i] != BPL) bad = 1;
            e_last = 1; e_done = 1; e_cnt = (e_cnt + 1) % 65536; e_bytes = beats;
            e_lines = SC ? runs.size() : 0;
            e_err = SC && (beats != BPL * NL || runs.size() != NL || bad);
            if (cont_m && !stop_m) begin
              beats = 0; runs.delete(); run_len = 0; sof_m = 1;
            end else mode = 0;
          end
        end
      end else if (mode == 1) begin
        if (stop) mode = 0;
        else if (s_tvalid && s_tlast) begin
          mode = 2; beats = 0; runs.delete(); run_len = 0; sof_m = 1; stop_m = 0;
        end
      end else if (start) begin
        mode = 1; cont_m = continuous;
      end
      href_prev = href_in;
      e_busy = (mode != 0) || e_last;
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("m_tvalid", m_tvalid, e_valid);
      chk("m_tdata", m_tdata, e_data);
      chk("m_tuser", m_tuser, e_user);
      chk("m_tlast", m_tlast, e_last);
      chk("frame_done", frame_done, e_done);
      chk("frame_err", frame_err, e_err);
      chk("frame_cnt", frame_cnt, e_cnt);
      chk("last_bytes", last_bytes, e_bytes);
      chk("last_lines", last_lines, e_lines);
      chk("busy", busy, e_busy);
      fwd_beats += int'(m_tvalid === 1'b1);
      sof_beats += int'(m_tuser === 1'b1);
    end
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n, input bit st = 0, input bit ct = 0, input bit sp = 0);
    continuous = ct; start = st; stop = sp;
    tick();
    start = 0; stop = 0;
    for (int i = 1; i < n; i++) tick();
  endtask

  // Receiver-like stream: beats trail href by one cycle, so tlast lands on the last href fall
  task automatic send_frame(input int a, input int b, input int c,
                            input int st_at = -1, input int sp_at = -1, input int rs_at = -1);
    int lens[3];
    bit hv[$];
    int last1;
    lens[0] = a; lens[1] = b; lens[2] = c;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < lens[l]; i++) hv.push_back(1'b1);
      hv.push_back(1'b0); hv.push_back(1'b0);
    end
    last1 = hv.size() - 3;
    for (int k = 0; k < hv.size(); k++) begin
      href_in  = hv[k];
      s_tvalid = (k > 0) && hv[k-1];
      s_tlast  = s_tvalid && (k - 1 == last1);
      if (s_tvalid) begin s_tdata = dctr; dctr = dctr + 8'd7; end
      start = (k == st_at); stop = (k == sp_at); rst = (k == rs_at);
      tick();
    end
    start = 0; stop = 0; rst = 0; s_tvalid = 0; s_tlast = 0; href_in = 0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    @(negedge pclk);
    chk("rst_busy", busy, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick();
    rst = 0;
    idle(2);

    // single-shot armed mid-frame: partial frame dropped, next whole frame forwarded
    send_frame(4, 4, 4, 5);
    send_frame(4, 4, 4);
    idle(3);
    @(negedge pclk);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_last_bytes", last_bytes, 12);
    chk("t1_last_lines", last_lines, SC ? 3 : 0);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_fwd_beats", fwd_beats, 12);
    chk("t1_sof_beats", sof_beats, 1);
    chk("t1_busy", busy, 0);

    // continuous: arming frame, then three frames with stop during the third
    idle(2, 1, 1);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4, -1, 6);
    idle(3);
    @(negedge pclk);
    chk("t2_frame_cnt", frame_cnt, 4);
    chk("t2_fwd_beats", fwd_beats, 48);
    chk("t2_sof_beats", sof_beats, 4);
    chk("t2_busy", busy, 0);

    // 5-byte first line, then a clean frame
    idle(2, 1, 0);
    send_frame(4, 4, 4);
    send_frame(5, 4, 4);
    idle(2);
    @(negedge pclk);
    chk("t3_bad_err", frame_err, SC ? 1 : 0);
    chk("t3_bad_bytes", last_bytes, 13);
    chk("t3_bad_lines", last_lines, SC ? 3 : 0);
    idle(2, 1, 0);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4);
    idle(2);
    @(negedge pclk);
    chk("t3_good_err", frame_err, 0);
    chk("t3_frame_cnt", frame_cnt, 6);
    chk("t3_fwd_beats", fwd_beats, 73);

    // stop while armed: back to idle next cycle, nothing forwarded
    idle(3, 1, 0);
    @(negedge pclk);
    chk("t4_busy_armed", busy, 1);
    idle(1, 0, 0, 1);
    @(negedge pclk);
    chk("t4_busy_after_stop", busy, 0);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4);
    idle(2);
    @(negedge pclk);
    chk("t4_fwd_beats", fwd_beats, 73);
    chk("t4_frame_cnt", frame_cnt, 6);

    // reset mid-capture, then a normal capture
    idle(2, 1, 0);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4, -1, -1, 8);
    idle(2);
    @(negedge pclk);
    chk("t5_rst_frame_cnt", frame_cnt, 0);
    chk("t5_rst_last_bytes", last_bytes, 0);
    chk("t5_rst_busy", busy, 0);
    idle(2, 1, 0);
    send_frame(4, 4, 4);
    send_frame(4, 4, 4);
    idle(2);
    @(negedge pclk);
    chk("t5_frame_cnt", frame_cnt, 1);
    chk("t5_last_bytes", last_bytes, 12);
    chk("t5_frame_err", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
